// File: rtl/alu_seq_ctrl_pkg.sv
// Shared constants and types for the ALU sequencing controller.
// Imported by the decoder, the FSM and the handshake interface.
package alu_seq_ctrl_pkg;

  localparam int IW = 16;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_GET_A  = 3'd2;
  localparam logic [2:0] S_GET_B  = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WR_REG = 3'd5;
  localparam logic [2:0] S_WR_IMM = 3'd6;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  typedef enum logic [2:0] {
    K_ILL, K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN
  } kind_t;

  typedef struct packed {
    kind_t          kind;
    logic [1:0]     op;
    logic [2:0]     rn;
    logic [2:0]     rd;
    logic [2:0]     rm;
    logic [1:0]     sh;
    logic [IW-1:0]  sximm8;
  } instr_f_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Start handshake plus datapath control bundle.
// master: instruction source; slave: the sequencer.
interface alu_seq_ctrl_if;
  import alu_seq_ctrl_pkg::*;

  logic          s;
  logic [IW-1:0] in;
  logic          w;
  logic          err;
  logic [2:0]    rnum;
  logic          write;
  logic          vsel;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic [1:0]    ALUop;
  logic [1:0]    shift;
  logic [IW-1:0] sximm8;

  modport master (
    output s, in,
    input  w, err, rnum, write, vsel, loada, loadb,
    input  loadc, loads, asel, ALUop, shift, sximm8
  );

  modport slave (
    input  s, in,
    output w, err, rnum, write, vsel, loada, loadb,
    output loadc, loads, asel, ALUop, shift, sximm8
  );

endinterface

// File: rtl/alu_seq_ctrl_instr_dec.sv
// Combinational instruction field extraction and legality check.
// Shared by the sequencer and a future fetch unit.
module instr_dec
  import alu_seq_ctrl_pkg::*;
(
  input  logic [IW-1:0] ir,
  output instr_f_t      f,
  output logic          legal
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc = ir[15:13];
  assign op  = ir[12:11];

  always_comb begin
    f        = '0;
    f.op     = op;
    f.rn     = ir[10:8];
    f.rd     = ir[7:5];
    f.sh     = ir[4:3];
    f.rm     = ir[2:0];
    f.sximm8 = {{8{ir[7]}}, ir[7:0]};
    f.kind   = K_ILL;
    unique case ({opc, op})
      {OPC_MOV, OP_MOVI}: f.kind = K_MOVI;
      {OPC_MOV, OP_MOVR}: f.kind = K_MOVR;
      {OPC_ALU, OP_ADD}:  f.kind = K_ADD;
      {OPC_ALU, OP_CMP}:  f.kind = K_CMP;
      {OPC_ALU, OP_AND}:  f.kind = K_AND;
      {OPC_ALU, OP_MVN}:  f.kind = K_MVN;
      default:            f.kind = K_ILL;
    endcase
  end

  assign legal = (f.kind != K_ILL);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Moore FSM sequencing the 16-bit ALU datapath, one instruction
// per start handshake; outputs depend only on state and IR.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  alu_seq_ctrl_if.slave bus
);

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [IW-1:0] ir;
  instr_f_t      f;
  logic          legal;

  instr_dec u_dec (
    .ir    (ir),
    .f     (f),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (state == S_WAIT && bus.s)
        ir <= bus.in;
    end
  end

  always_comb begin
    nxt = S_WAIT;
    case (state)
      S_WAIT:   nxt = bus.s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        unique case (f.kind)
          K_MOVI:              nxt = S_WR_IMM;
          K_MOVR, K_MVN:       nxt = S_GET_B;
          K_ADD, K_CMP, K_AND: nxt = S_GET_A;
          default:             nxt = S_WAIT;
        endcase
      end
      S_GET_A:  nxt = S_GET_B;
      S_GET_B:  nxt = S_EXEC;
      S_EXEC:   nxt = (f.kind == K_CMP) ? S_WAIT : S_WR_REG;
      default:  nxt = S_WAIT;
    endcase
  end

  always_comb begin
    bus.w      = 1'b0;
    bus.err    = 1'b0;
    bus.rnum   = '0;
    bus.write  = 1'b0;
    bus.vsel   = 1'b0;
    bus.loada  = 1'b0;
    bus.loadb  = 1'b0;
    bus.loadc  = 1'b0;
    bus.loads  = 1'b0;
    bus.asel   = 1'b0;
    bus.ALUop  = ALU_ADD;
    bus.shift  = 2'b00;
    case (state)
      S_WAIT:   bus.w = 1'b1;
      S_DECODE: bus.err = !legal;
      S_GET_A: begin
        bus.rnum  = f.rn;
        bus.loada = 1'b1;
      end
      S_GET_B: begin
        bus.rnum  = f.rm;
        bus.loadb = 1'b1;
      end
      S_EXEC: begin
        // MOV reg is 0 + shifted B, so it borrows the ADD path
        bus.shift = f.sh;
        bus.ALUop = (f.kind == K_MOVR) ? ALU_ADD : f.op;
        bus.asel  = (f.kind == K_MOVR) || (f.kind == K_MVN);
        bus.loads = 1'b1;
        bus.loadc = (f.kind != K_CMP);
      end
      S_WR_REG: begin
        bus.rnum  = f.rd;
        bus.write = 1'b1;
      end
      S_WR_IMM: begin
        bus.rnum  = f.rn;
        bus.vsel  = 1'b1;
        bus.write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.sximm8 = f.sximm8;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a per-cycle expected-control
// scoreboard filled from an independent instruction model.
module tb_alu_seq_ctrl;

  typedef struct packed {
    logic       w;
    logic       err;
    logic [2:0] rnum;
    logic       write;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] aluop;
    logic [1:0] shift;
  } ctl_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ctl_t        q[$];
  logic [15:0] qimm[$];

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t obs();
    ctl_t o;
    o.w     = bus.w;
    o.err   = bus.err;
    o.rnum  = bus.rnum;
    o.write = bus.write;
    o.vsel  = bus.vsel;
    o.loada = bus.loada;
    o.loadb = bus.loadb;
    o.loadc = bus.loadc;
    o.loads = bus.loads;
    o.asel  = bus.asel;
    o.aluop = bus.ALUop;
    o.shift = bus.shift;
    return o;
  endfunction

  task automatic push(input ctl_t e, input logic [15:0] imm);
    q.push_back(e);
    qimm.push_back(imm);
  endtask

  task automatic push_wait(input logic [15:0] imm);
    ctl_t e;
    e   = '0;
    e.w = 1'b1;
    push(e, imm);
  endtask

  task automatic push_seq(input logic [15:0] i);
    logic [2:0]  opc;
    logic [1:0]  op;
    logic [15:0] imm;
    bit movi, movr, alu, legal, cmp, mvn;
    ctl_t e;
    opc   = i[15:13];
    op    = i[12:11];
    imm   = {{8{i[7]}}, i[7:0]};
    movi  = (opc == 3'b110) && (op == 2'b10);
    movr  = (opc == 3'b110) && (op == 2'b00);
    alu   = (opc == 3'b101);
    legal = movi || movr || alu;
    cmp   = alu && (op == 2'b01);
    mvn   = alu && (op == 2'b11);
    e     = '0;
    e.err = !legal;
    push(e, imm);
    if (movi) begin
      e = '0;
      e.rnum = i[10:8];
      e.vsel = 1'b1;
      e.write = 1'b1;
      push(e, imm);
    end else if (legal) begin
      if (alu && !mvn) begin
        e = '0;
        e.rnum = i[10:8];
        e.loada = 1'b1;
        push(e, imm);
      end
      e = '0;
      e.rnum = i[2:0];
      e.loadb = 1'b1;
      push(e, imm);
      e = '0;
      e.shift = i[4:3];
      e.aluop = movr ? 2'b00 : op;
      e.asel  = movr || mvn;
      e.loads = 1'b1;
      e.loadc = !cmp;
      push(e, imm);
      if (!cmp) begin
        e = '0;
        e.rnum = i[7:5];
        e.write = 1'b1;
        push(e, imm);
      end
    end
    push_wait(imm);
  endtask

  task automatic check(input string tag);
    ctl_t e;
    ctl_t o;
    logic [15:0] ei;
    e  = q.pop_front();
    ei = qimm.pop_front();
    o  = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s ctl: got %h expected %h", tag, o, e);
    end
    checks++;
    assert (bus.sximm8 === ei) else begin
      errors++;
      $error("FAIL %s sximm8: got %h expected %h", tag, bus.sximm8, ei);
    end
  endtask

  task automatic run(input logic [15:0] i, input string tag,
                     input bit hold, input int abort);
    int n;
    push_seq(i);
    n = q.size();
    bus.s  = 1'b1;
    bus.in = i;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 && !hold) begin
        bus.s  = 1'b0;
        bus.in = 16'($urandom);
      end
      check(tag);
      if (k == abort) begin
        q.delete();
        qimm.delete();
        reset = 1'b1;
        push_wait(16'h0000);
        @(posedge clk);
        #1;
        check({tag, "_abort"});
        reset = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.s  = 1'b1;
    bus.in = 16'hD105;
    for (int c = 0; c < 3; c++) begin
      push_wait(16'h0000);
      @(posedge clk);
      #1;
      check("reset");
    end
    reset = 1'b0;
    run(16'hD105, "movi_after_reset", 1'b0, -1);
    run(16'hD1FD, "movi_neg", 1'b0, -1);
    run(16'hA140, "add", 1'b0, -1);
    run(16'hA900, "cmp", 1'b0, -1);
    run(16'hE000, "illegal_e000", 1'b0, -1);
    run(16'hB860, "mvn", 1'b0, -1);
    run(16'hC0AA, "movr_shift_b2b", 1'b1, -1);
    run(16'hB381, "and_b2b", 1'b1, -1);
    run(16'hC800, "illegal_c800", 1'b0, -1);
    run(16'hA140, "add_reset_exec", 1'b0, 3);
    run(16'hD1FD, "movi_post_abort", 1'b0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle Moore FSM that sequences the 16-bit ALU datapath: register file → A/B pipeline registers → ALU → C register / status register → register-file writeback.
- Accepts one 16-bit instruction per start handshake, latches it, and drives every datapath load and select line until the instruction retires.
- Sits between the instruction source (test harness or later fetch unit) and the datapath. It contains no datapath arithmetic itself.

Parameters:
- IW, 16, instruction and datapath word width. Only 16 is supported; the parameter is for documentation.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- s  in  1  start request
- in  in  16  instruction; sampled only on the accept edge
- w  out  1  ready/idle; 1 only in WAIT
- err  out  1  one-cycle pulse on an illegal instruction
- rnum  out  3  register-file read/write index
- write  out  1  register-file write enable
- vsel  out  1  writeback select: 0 = C register, 1 = sximm8
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C register
- loads  out  1  load status register (Z, V, N from the ALU)
- asel  out  1  1 forces the ALU A operand to 0
- ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT-B
- shift  out  2  shifter control on the B path
- sximm8  out  16  sign-extended imm8 from the latched instruction

Behaviour:
- Instruction fields:
  - [15:13] opcode
  - [12:11] op
  - [10:8] Rn
  - [7:5] Rd
  - [4:3] shift
  - [2:0] Rm
  - [7:0] imm8
- Legal encodings:
  - opcode 110, op 10: MOV Rn,#imm8
  - opcode 110, op 00: MOV Rd,Rm{shift}
  - opcode 101, op 00: ADD Rd,Rn,Rm
  - opcode 101, op 01: CMP Rn,Rm (status only)
  - opcode 101, op 10: AND Rd,Rn,Rm
  - opcode 101, op 11: MVN Rd,Rm
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM. State register is updated on clk rising edge only.
- Reset: when reset=1 at an edge, next state is WAIT. This overrides s and any in-flight instruction; the aborted instruction performs no further writes.
- Outputs in WAIT: w=1; write, loada, loadb, loadc, loads, err all 0; asel=0, vsel=0, ALUop=00, shift=00, rnum=0.
- Output style: Moore; every output is a function of state and latched instruction only. Outputs not listed for a state are 0.
- Accept: in WAIT, s=1 at an edge latches in into an internal IR and moves to DECODE. s in any other state is ignored. in is don't-care after the accept edge.
- Decode (DECODE):
  - MOV imm → WR_IMM
  - MOV reg, MVN → GET_B
  - ADD, CMP, AND → GET_A
  - illegal → WAIT, with err=1 during DECODE
- GET_A: rnum=Rn, loada=1 → GET_B.
- GET_B: rnum=Rm, loadb=1 → EXEC.
- EXEC: shift=IR[4:3]; ALUop=op, except MOV reg uses ADD; asel=1 for MOV reg and MVN.
  - CMP: ALUop=01, loads=1, loadc=0 → WAIT.
  - All others: loadc=1, loads=1 → WR_REG.
- WR_REG: rnum=Rd, vsel=0, write=1 → WAIT.
- WR_IMM: rnum=Rn, vsel=1, write=1 → WAIT.
- Latency (cycles from accept edge to w=1):
  - MOV imm: 3
  - MOV reg, MVN: 5
  - CMP: 5
  - ADD, AND: 6
  - illegal: 2
- Status ownership: loads is asserted for every executed ALU instruction; MOV imm never touches status.
- sximm8 = {{8{IR[7]}}, IR[7:0]}, valid from DECODE onward. Its value in WAIT after reset is 0 because IR resets to 0.
- s held high continuously: a new instruction is accepted on the first edge after w returns to 1, with no dead cycle.

Decomposition:
- Shared header with:
  - state encodings
  - opcode/op constants
  - ALUop constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_NOTB
- Small sub-module instr_dec: combinational field extraction plus the legal flag and sximm8. Used by this FSM and reusable by a future fetch unit.
- FSM and IR stay in alu_seq_ctrl.

Test Plan:
- Reset with s=1 and in=16'hD105 held → state WAIT, w=1, all enables 0 for 3 cycles after reset drops only if s=0; with s=1, accept occurs on the first edge after reset deasserts.
- MOV R1,#-3 (16'hD1FD) → after 3 cycles: write=1 in the final cycle, rnum=1, vsel=1, sximm8=16'hFFFD; no loads.
- ADD R2,R1,R0 (16'hA140) → GET_A rnum=1, GET_B rnum=0, EXEC ALUop=00 loadc=1 loads=1, WR_REG rnum=2 write=1; w back after 6 cycles.
- CMP R1,R0 (16'hA900) → EXEC ALUop=01 loads=1; loadc and write never asserted; w back after 5 cycles.
- Illegal 16'hE000 → err=1 for exactly one cycle, no enables, w=1 after 2 cycles. Then MVN R3,R0 (16'hB860) → asel=1, ALUop=11, rnum=3 write=1.
- Reset asserted during EXEC of ADD → next cycle WAIT; write never asserted; subsequent MOV completes normally.
